// File: rtl/avm_i2s_rx_if.sv
// Avalon-MM write-master bus that carries captured I2S samples into a memory ring buffer.
interface avm_i2s_rx_if;
  logic [31:0] avm_m0_address;
  logic        avm_m0_write;
  logic [31:0] avm_m0_writedata;
  logic        avm_m0_waitrequest;

  modport master (
    output avm_m0_address,
    output avm_m0_write,
    output avm_m0_writedata,
    input  avm_m0_waitrequest
  );

  modport slave (
    input  avm_m0_address,
    input  avm_m0_write,
    input  avm_m0_writedata,
    output avm_m0_waitrequest
  );
endinterface

// File: rtl/avm_i2s_rx.sv
// I2S receiver feeding a sample FIFO that an Avalon-MM master drains into a ring buffer.
// Optional macro AVM_I2S_RX_SIGNEXT_EN sign-extends samples to 32 bits instead of zero-extending.
module avm_i2s_rx #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned BUF_WORDS  = 256,
  parameter int unsigned DATA_BITS  = 24,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         i2s_sck,
  input  logic         i2s_ws,
  input  logic         i2s_sd,
  avm_i2s_rx_if.master avm,
  output logic         buf_wrap,
  output logic         overflow
);

  localparam int unsigned PTR_W = (BUF_WORDS > 1) ? $clog2(BUF_WORDS) : 1;
  localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);
  localparam int unsigned FA_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FC_W  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  function automatic logic [31:0] extend(input logic [DATA_BITS-1:0] s);
`ifdef AVM_I2S_RX_SIGNEXT_EN
    return 32'(signed'(s));
`else
    return 32'(s);
`endif
  endfunction

  // ---------------------------------------------------------------- synchronisers
  logic [1:0] sck_sync;
  logic [1:0] ws_sync;
  logic [1:0] sd_sync;
  logic       sck_prev;
  logic       sck_rise;
  logic       ws_s;
  logic       sd_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      sd_sync  <= '0;
      sck_prev <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[0], i2s_sck};
      ws_sync  <= {ws_sync[0], i2s_ws};
      sd_sync  <= {sd_sync[0], i2s_sd};
      sck_prev <= sck_sync[1];
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_prev;
  assign ws_s     = ws_sync[1];
  assign sd_s     = sd_sync[1];

  // ---------------------------------------------------------------- serial receiver
  // A slot can only open after a WS change seen while enabled, so clearing the
  // open/active flags whenever enable is low gives the sync-wait for free.
  logic                 ws_last;
  logic                 ws_seen;
  logic                 open_pend;
  logic                 slot_active;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 push_pend;
  logic                 ws_change;

  assign ws_change = ws_seen & (ws_s != ws_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ws_last     <= 1'b0;
      ws_seen     <= 1'b0;
      open_pend   <= 1'b0;
      slot_active <= 1'b0;
      bit_cnt     <= '0;
      shreg       <= '0;
      push_pend   <= 1'b0;
    end else begin
      push_pend <= 1'b0;
      if (sck_rise) begin
        ws_last <= ws_s;
        ws_seen <= 1'b1;
      end
      if (!enable) begin
        open_pend   <= 1'b0;
        slot_active <= 1'b0;
      end else if (sck_rise) begin
        if (ws_change) begin
          // Ending a slot here discards it unless its word was already pushed.
          open_pend   <= 1'b1;
          slot_active <= 1'b0;
        end else if (open_pend) begin
          open_pend   <= 1'b0;
          slot_active <= 1'b1;
          shreg       <= DATA_BITS'(sd_s);
          bit_cnt     <= CNT_W'(1);
        end else if (slot_active && (bit_cnt < CNT_W'(DATA_BITS))) begin
          shreg     <= {shreg[DATA_BITS-2:0], sd_s};
          bit_cnt   <= bit_cnt + CNT_W'(1);
          push_pend <= (bit_cnt == CNT_W'(DATA_BITS - 1));
        end
      end
    end
  end

  // ---------------------------------------------------------------- sample FIFO
  logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [FA_W-1:0]      wr_idx;
  logic [FA_W-1:0]      rd_idx;
  logic [FC_W-1:0]      fifo_cnt;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 push;
  logic                 push_ok;
  logic                 pop;
  logic [DATA_BITS-1:0] fifo_head;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FC_W'(FIFO_DEPTH));
  assign push       = push_pend & enable;
  assign push_ok    = push & (~fifo_full | pop);
  assign fifo_head  = fifo_mem[rd_idx];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_idx] <= shreg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_idx   <= '0;
      rd_idx   <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_idx <= (wr_idx == FA_W'(FIFO_DEPTH - 1)) ? '0 : wr_idx + FA_W'(1);
      end
      if (pop) begin
        rd_idx <= (rd_idx == FA_W'(FIFO_DEPTH - 1)) ? '0 : rd_idx + FA_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + FC_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - FC_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- write master
  state_t           state;
  state_t           state_nxt;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic             ptr_last;
  logic             accept;
  logic             write_q;
  logic             write_nxt;
  logic [31:0]      wdata_q;
  logic [31:0]      wdata_nxt;
  logic [31:0]      addr_q;

  assign ptr_last = (ptr == PTR_W'(BUF_WORDS - 1));
  assign accept   = (state == WRITE) & ~avm.avm_m0_waitrequest;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      addr_q  <= BASE_ADDR;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      write_q <= write_nxt;
      wdata_q <= wdata_nxt;
      addr_q  <= BASE_ADDR + (32'(ptr_nxt) << 2);
    end
  end

  // Next beat is loaded straight from the FIFO head, back-to-back when data is waiting.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    write_nxt = write_q;
    wdata_nxt = wdata_q;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        write_nxt = 1'b0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          wdata_nxt = extend(fifo_head);
          write_nxt = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (accept) begin
          ptr_nxt = ptr_last ? '0 : ptr + PTR_W'(1);
          if (!fifo_empty) begin
            pop       = 1'b1;
            wdata_nxt = extend(fifo_head);
          end else begin
            write_nxt = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        write_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign avm.avm_m0_address   = addr_q;
  assign avm.avm_m0_write     = write_q;
  assign avm.avm_m0_writedata = wdata_q;
  assign buf_wrap             = accept & ptr_last;

endmodule

// File: tb/tb_avm_i2s_rx.sv
// Bench for avm_i2s_rx: drives I2S frames, stalls the Avalon slave, and scores every accepted write.
module tb_avm_i2s_rx;

  localparam logic [31:0] BASE     = 32'h0000_1000;
  localparam int unsigned BUFW     = 4;
  localparam int          HALF_SCK = 4;

`ifdef AVM_I2S_RX_SIGNEXT_EN
  localparam logic [31:0] EXP_800001 = 32'hFF80_0001;
  localparam logic [31:0] EXP_FFFFFF = 32'hFFFF_FFFF;
  localparam logic [31:0] EXP_A5A5A5 = 32'hFFA5_A5A5;
`else
  localparam logic [31:0] EXP_800001 = 32'h0080_0001;
  localparam logic [31:0] EXP_FFFFFF = 32'h00FF_FFFF;
  localparam logic [31:0] EXP_A5A5A5 = 32'h00A5_A5A5;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic i2s_sck = 1'b0;
  logic i2s_ws = 1'b1;
  logic i2s_sd = 1'b0;
  logic buf_wrap;
  logic overflow;

  avm_i2s_rx_if bus ();

  avm_i2s_rx #(
    .BASE_ADDR (BASE),
    .BUF_WORDS (BUFW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .i2s_sck  (i2s_sck),
    .i2s_ws   (i2s_ws),
    .i2s_sd   (i2s_sd),
    .avm      (bus.master),
    .buf_wrap (buf_wrap),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Slave model: 0 = ready, 1 = stalled, 2 = random stall each cycle.
  int wr_mode = 0;
  initial begin
    bus.avm_m0_waitrequest = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.avm_m0_waitrequest = (wr_mode == 2) ? 1'($urandom_range(0, 1)) : (wr_mode == 1);
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wrap;
  } beat_t;

  beat_t beat_q[$];
  int    wrap_pulses = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.avm_m0_write && !bus.avm_m0_waitrequest)
        beat_q.push_back('{bus.avm_m0_address, bus.avm_m0_writedata, buf_wrap});
      if (buf_wrap) wrap_pulses++;
    end
  end

  // Reference model: expected words in order, and the ring position of the next beat.
  logic [31:0] exp_q[$];
  int          rd = 0;
  int          nbeat = 0;

  function automatic logic [31:0] model_word(input logic [23:0] s);
`ifdef AVM_I2S_RX_SIGNEXT_EN
    return (s >= 24'h80_0000) ? 32'(s) + 32'hFF00_0000 : 32'(s);
`else
    return 32'(s);
`endif
  endfunction

  task automatic check_beats(input string tag);
    int n;
    int t;
    beat_t b;
    n = exp_q.size();
    t = 0;
    while ((beat_q.size() - rd) < n && t < 4000) begin
      @(posedge clk);
      t++;
    end
    repeat (40) @(posedge clk);
    if ((beat_q.size() - rd) < n) begin
      checks++;
      $display("FAIL %s beat count: got %0d beats, expected %0d", tag, beat_q.size() - rd, n);
    end else begin
      for (int i = 0; i < n; i++) begin
        b = beat_q[rd];
        rd++;
        check32({tag, " data"}, b.data, exp_q[i]);
        check32({tag, " addr"}, b.addr, BASE + 32'(4 * (nbeat % BUFW)));
        check32({tag, " buf_wrap"}, 32'(b.wrap), 32'((nbeat % BUFW) == (BUFW - 1)));
        nbeat++;
      end
      check32({tag, " surplus beats"}, 32'(beat_q.size() - rd), 32'd0);
    end
    rd = beat_q.size();
    exp_q.delete();
  endtask

  task automatic sck_edge(input logic ws, input logic sd);
    i2s_sck = 1'b0;
    i2s_ws  = ws;
    i2s_sd  = sd;
    repeat (HALF_SCK) @(posedge clk);
    #2 i2s_sck = 1'b1;
    repeat (HALF_SCK) @(posedge clk);
    #2;
  endtask

  // Edge 0 carries the WS change; edges 1..len carry lj MSB-first. enable is set at edge en_edge.
  task automatic send_slot(input logic c, input logic [31:0] lj, input int len,
                           input int en_edge, input logic en_val);
    for (int i = 0; i <= len; i++) begin
      if (i == en_edge) enable = en_val;
      sck_edge(c, (i == 0) ? 1'b0 : lj[32-i]);
    end
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
    send_slot(1'b0, {l, 8'($urandom)}, 31, -1, 1'b0);
    send_slot(1'b1, {r, 8'($urandom)}, 31, -1, 1'b0);
  endtask

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic [31:0] exp_l;
    logic [31:0] exp_r;
  } vec_t;

  vec_t        vecs[3];
  logic [23:0] l;
  logic [23:0] r;
  int          w0;

  initial begin
    vecs[0] = '{24'h80_0001, 24'h7F_FFFE, EXP_800001, 32'h007F_FFFE};
    vecs[1] = '{24'hFF_FFFF, 24'h00_0000, EXP_FFFFFF, 32'h0000_0000};
    vecs[2] = '{24'hA5_A5A5, 24'h12_3456, EXP_A5A5A5, 32'h0012_3456};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("reset write", 32'(bus.avm_m0_write), 32'd0);
    check32("reset address", bus.avm_m0_address, BASE);
    check32("reset writedata", bus.avm_m0_writedata, 32'd0);
    check32("reset buf_wrap", 32'(buf_wrap), 32'd0);
    check32("reset overflow", 32'(overflow), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    enable = 1'b1;
    repeat (3) sck_edge(1'b1, 1'b0);

    // Directed frames: 6 samples into a 4-word ring, wrapping once.
    w0 = wrap_pulses;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(vecs[k].exp_l);
      exp_q.push_back(vecs[k].exp_r);
      send_frame(vecs[k].l, vecs[k].r);
    end
    check_beats("table");
    check32("buf_wrap pulse count", 32'(wrap_pulses - w0), 32'd1);

    // Short 16-bit slot is discarded; the following full slots are kept.
    send_slot(1'b0, $urandom, 16, -1, 1'b0);
    r = 24'h3C_3C3C;
    exp_q.push_back(model_word(r));
    send_slot(1'b1, {r, 8'hFF}, 31, -1, 1'b0);
    l = 24'hC0_FFEE;
    exp_q.push_back(model_word(l));
    send_slot(1'b0, {l, 8'hFF}, 31, -1, 1'b0);
    check_beats("short slot");

    // Hold waitrequest for 10 cycles during a write.
    wr_mode = 1;
    l = 24'($urandom);
    r = 24'($urandom);
    exp_q.push_back(model_word(l));
    exp_q.push_back(model_word(r));
    fork
      send_slot(1'b1, {l, 8'h00}, 31, -1, 1'b0);
      begin : hold_watch
        int t;
        t = 0;
        while (!bus.avm_m0_write && t < 2000) begin
          @(negedge clk);
          t++;
        end
        check32("hold write seen", 32'(bus.avm_m0_write), 32'd1);
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          check32("hold write", 32'(bus.avm_m0_write), 32'd1);
          check32("hold address", bus.avm_m0_address, BASE + 32'(4 * (nbeat % BUFW)));
          check32("hold writedata", bus.avm_m0_writedata, exp_q[0]);
        end
        check32("hold no acceptance", 32'(beat_q.size() - rd), 32'd0);
        wr_mode = 0;
      end
    join
    send_slot(1'b0, {r, 8'h00}, 31, -1, 1'b0);
    check_beats("hold");

    // Permanent stall across 6 samples: 1 in flight, 4 queued, 1 dropped.
    wr_mode = 1;
    check32("overflow clear", 32'(overflow), 32'd0);
    for (int k = 0; k < 3; k++) begin
      l = 24'($urandom);
      r = 24'($urandom);
      exp_q.push_back(model_word(l));
      if (k < 2) exp_q.push_back(model_word(r));
      send_slot(1'b1, {l, 8'h00}, 31, -1, 1'b0);
      send_slot(1'b0, {r, 8'h00}, 31, -1, 1'b0);
    end
    check32("overflow set", 32'(overflow), 32'd1);
    check32("no beats while stalled", 32'(beat_q.size() - rd), 32'd0);
    wr_mode = 0;
    check_beats("overflow drain");
    check32("overflow sticky", 32'(overflow), 32'd1);

    // Enable dropped mid-slot, then raised after a WS change: only later slots are kept.
    send_slot(1'b1, $urandom, 31, 10, 1'b0);
    send_slot(1'b0, $urandom, 31, -1, 1'b0);
    send_slot(1'b1, $urandom, 31, 1, 1'b1);
    l = 24'h5A_0F0F;
    r = 24'h81_2345;
    exp_q.push_back(model_word(l));
    exp_q.push_back(model_word(r));
    send_slot(1'b0, {l, 8'h00}, 31, -1, 1'b0);
    send_slot(1'b1, {r, 8'h00}, 31, -1, 1'b0);
    check_beats("enable");

    // Random samples under random slave stalls.
    wr_mode = 2;
    for (int k = 0; k < 8; k++) begin
      l = 24'($urandom);
      r = 24'($urandom);
      exp_q.push_back(model_word(l));
      exp_q.push_back(model_word(r));
      send_frame(l, r);
    end
    wr_mode = 0;
    check_beats("random");

    // Reset while a stalled write is outstanding.
    wr_mode = 1;
    send_slot(1'b0, {24'h13_5790, 8'h00}, 31, -1, 1'b0);
    check32("pre-reset write pending", 32'(bus.avm_m0_write), 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check32("async reset write", 32'(bus.avm_m0_write), 32'd0);
    check32("async reset address", bus.avm_m0_address, BASE);
    check32("async reset writedata", bus.avm_m0_writedata, 32'd0);
    check32("async reset buf_wrap", 32'(buf_wrap), 32'd0);
    check32("async reset overflow", 32'(overflow), 32'd0);
    repeat (2) @(posedge clk);
    #1 check32("held reset write", 32'(bus.avm_m0_write), 32'd0);
    wr_mode = 0;
    rd = beat_q.size();
    nbeat = 0;
    exp_q.delete();
    #1 reset = 1'b0;

    // After reset the pointer restarts at the base address.
    repeat (2) sck_edge(1'b1, 1'b0);
    l = 24'h00_0F00;
    r = 24'hF0_0001;
    exp_q.push_back(model_word(l));
    exp_q.push_back(model_word(r));
    send_frame(l, r);
    check_beats("post reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

endmodule
